// File: rtl/ysyx_23060171_pcupd_if.sv
// EXU resolution inputs plus the PC/IFU fetch handshake, grouped as one bus.
// The slave modport is the PC update block's view; master is the EXU/IFU side.
interface ysyx_23060171_pcupd_if #(
  parameter int XLEN = 32
);
  logic            exu_valid;
  logic            exu_ready;
  logic [2:0]      PCSrc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            pc_valid;
  logic            ifu_ready;
  logic [XLEN-1:0] pc;

  modport master (
    output exu_valid, PCSrc, imm, rs_val, mtvec, mepc, ifu_ready,
    input  exu_ready, pc_valid, pc
  );

  modport slave (
    input  exu_valid, PCSrc, imm, rs_val, mtvec, mepc, ifu_ready,
    output exu_ready, pc_valid, pc
  );
endinterface

// File: rtl/ysyx_23060171_pcupd.sv
// PC register + next-PC select; new pc valid 1 cycle after EXU handshake, held stable until IFU ready.
// Optional MISALIGN_CHK_EN: misaligned targets redirect to mtvec and pulse misalign.
module ysyx_23060171_pcupd #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_23060171_pcupd_if.slave       bus,
  output logic [63:0]                ret_cnt
`ifdef MISALIGN_CHK_EN
  ,
  output logic                       misalign
`endif
);

  typedef enum logic [1:0] {S_RST, S_ISSUE, S_WAIT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            exu_ready_q;
  logic [63:0]     ret_cnt_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] trap_pc;

  assign trap_pc = bus.mtvec & ~XLEN'(3);

  always_comb begin
    next_pc = pc_q + XLEN'(4);
    case (bus.PCSrc)
      3'b001:  next_pc = pc_q + bus.imm;
      3'b010:  next_pc = (bus.rs_val + bus.imm) & ~XLEN'(1);
      3'b011:  next_pc = trap_pc;
      3'b100:  next_pc = bus.mepc;
      default: next_pc = pc_q + XLEN'(4);
    endcase
  end

`ifdef MISALIGN_CHK_EN
  logic misalign_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RST;
      pc_q        <= XLEN'(RESET_PC);
      pc_valid_q  <= 1'b0;
      exu_ready_q <= 1'b0;
      ret_cnt_q   <= 64'd0;
`ifdef MISALIGN_CHK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
      case (state)
        S_RST: begin
          state       <= S_ISSUE;
          pc_valid_q  <= 1'b1;
          exu_ready_q <= 1'b0;
        end
        S_ISSUE: begin
          if (bus.ifu_ready) begin
            state       <= S_WAIT;
            pc_valid_q  <= 1'b0;
            exu_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.exu_valid) begin
            state       <= S_ISSUE;
            pc_valid_q  <= 1'b1;
            exu_ready_q <= 1'b0;
            ret_cnt_q   <= ret_cnt_q + 64'd1;
`ifdef MISALIGN_CHK_EN
            // The redirect is itself aligned, so it never re-triggers.
            if (next_pc[1:0] != 2'b00) begin
              pc_q       <= trap_pc;
              misalign_q <= 1'b1;
            end else begin
              pc_q <= next_pc;
            end
`else
            pc_q <= next_pc;
`endif
          end
        end
        default: begin
          state       <= S_RST;
          pc_valid_q  <= 1'b0;
          exu_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.exu_ready = exu_ready_q;
  assign ret_cnt       = ret_cnt_q;
`ifdef MISALIGN_CHK_EN
  assign misalign      = misalign_q;
`endif

endmodule

// File: doc/ysyx_23060171_pcupd.md
Name: ysyx_23060171_pcupd

Overview:
- Consumer end of the PCSrc select code produced by branch/jump resolution.
- Holds the architectural PC and computes the next PC from PCSrc and the resolved operands.
- Presents each PC to the IFU over a valid/ready handshake.
- Sits between EXU (resolution) and IFU (fetch); counts retired control decisions.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded by reset.
- XLEN, 32, address/data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- exu_valid  input  1  EXU presents a resolved PCSrc/operand set.
- exu_ready  output  1  block accepts a resolution this cycle.
- PCSrc  input  3  000 pc+4, 001 pc+imm, 010 rs+imm, 011 mtvec, 100 mepc.
- imm  input  XLEN  sign-extended immediate.
- rs_val  input  XLEN  source register value (JALR base).
- mtvec  input  XLEN  trap vector CSR.
- mepc  input  XLEN  exception PC CSR.
- pc_valid  output  1  pc holds a fetch address for IFU.
- ifu_ready  input  1  IFU accepts pc.
- pc  output  XLEN  current PC.
- ret_cnt  output  64  number of accepted EXU resolutions.
- misalign  output  1  (MISALIGN_CHK_EN only) pulse: last computed target was misaligned.

Behaviour:
- States: S_RST, S_ISSUE, S_WAIT.
- Reset (rst_n low at a clock edge), applied in any state including mid-handshake:
  - state=S_RST, pc=RESET_PC, pc_valid=0, exu_ready=0, ret_cnt=0, misalign=0.
- S_RST: on the first edge with rst_n high, go to S_ISSUE. pc_valid=1 is visible the cycle after reset release.
- S_ISSUE:
  - pc_valid=1, exu_ready=0.
  - pc and pc_valid stay stable until pc_valid&&ifu_ready.
  - On fire, go to S_WAIT; pc_valid drops the next cycle.
- S_WAIT:
  - pc_valid=0, exu_ready=1.
  - On exu_valid&&exu_ready: pc <= next_pc, ret_cnt <= ret_cnt+1, go to S_ISSUE.
  - New pc is visible, with pc_valid=1, exactly one cycle after the EXU handshake.
  - exu_valid without S_WAIT is ignored; EXU must hold its inputs.
- next_pc, modulo 2^XLEN with wrap-around and no flag:
  - 000: pc+4.
  - 001: pc+imm.
  - 010: (rs_val+imm) & ~1.
  - 011: {mtvec[XLEN-1:2],2'b00}.
  - 100: mepc.
  - 101..111: pc+4 (treated as no-jump).
  - Example: pc=FFFF_FFFC with 000 -> 0000_0000.
- ret_cnt is 64-bit and wraps from all-ones to 0.
- Only one resolution is outstanding per issued PC; no buffering beyond the PC register.

Optional Feature:
- Macro: MISALIGN_CHK_EN.
- Defined:
  - If next_pc[1:0]!=0, pc loads {mtvec[XLEN-1:2],2'b00} instead.
  - misalign pulses 1 for the single cycle in which the redirected pc is first valid.
  - ret_cnt still increments.
- Undefined:
  - next_pc is loaded unchanged (bit 0 cleared only for 010).
  - misalign port is absent.

Test Plan:
- Reset release, ifu_ready=1 -> pc=8000_0000, pc_valid=1 the cycle after rst_n rises; ret_cnt=0.
- Fire; EXU PCSrc=000 -> pc=8000_0004 one cycle after handshake; ret_cnt=1.
- pc=8000_0010, PCSrc=001, imm=FFFF_FFF0 -> 8000_0000; PCSrc=010, rs_val=8000_1001, imm=2 -> 8000_1002.
- ifu_ready low 5 cycles in S_ISSUE -> pc/pc_valid stable, exu_ready=0, exu_valid pulse ignored, ret_cnt unchanged.
- PCSrc=011, mtvec=8000_0103 -> 8000_0100; PCSrc=100, mepc=8000_0040 -> 8000_0040; PCSrc=111 at pc=FFFF_FFFC -> 0000_0000.
- rst_n low during S_WAIT with exu_valid=1 -> no update, pc=8000_0000, ret_cnt=0. With MISALIGN_CHK_EN, PCSrc=001, imm=2 -> pc=mtvec target and one-cycle misalign.
